alu_scheduler: RTL and testbench
================================

Name: alu_scheduler

Overview:
- Shares one combinational 32-bit ALU (7-bit op code) between two requesters.
- Round-robin arbitration; accepted operands and op are latched and held on the ALU inputs for an op-dependent number of cycles, so MUL/DIV get multicycle paths. The result is then returned on a single response channel tagged with the requester ID.
- Flags unsupported ops and divide-by-zero.
- Sits between the instruction decode/issue logic and the ALU instance.

Parameters:
- WIDTH, 32, operand/result width (must match ALU)
- MUL_CYCLES, 2, cycles ALU inputs held stable for op 7'b0000010 (min 1)
- DIV_CYCLES, 4, cycles ALU inputs held stable for op 7'b0000011 (min 1)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an op
- req0_ready  output  1  requester 0 op accepted this cycle
- req0_a, req0_b  input  WIDTH  operands, requester 0
- req0_op  input  7  op code, requester 0
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same for requester 1
- alu_a, alu_b  output  WIDTH  registered operands to ALU
- alu_op  output  7  registered op code to ALU
- alu_result  input  WIDTH  ALU combinational result
- resp_valid  output  1  response available
- resp_ready  input  1  consumer accepts response
- resp_data  output  WIDTH  result
- resp_id  output  1  requester that issued the op
- resp_err  output  1  unsupported op or divide by zero
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE, counter=0, last_grant=1 (req0 wins first tie).
  - alu_a/alu_b/alu_op=0; resp_valid/resp_data/resp_id/resp_err=0; busy=0.
  - Any in-flight op is dropped and produces no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational: high only for the granted requester, and only while in IDLE.
  - Grant rules:
    - Only one valid: grant it.
    - Both valid: grant the one not equal to last_grant.
    - Neither valid: stay in IDLE.
  - On grant: latch a/b/op into alu_a/alu_b/alu_op, latch id, set last_grant=id, and load counter with L-1.
  - L = MUL_CYCLES for op 2, DIV_CYCLES for op 3, and 1 for all other ops. Next state is EXEC.
- EXEC:
  - ALU inputs are held constant.
  - If counter≠0, decrement it.
  - If counter==0, capture the result into resp_data and move to RESP. The captured value is:
    - op > 7'b0001010: resp_data=0, resp_err=1.
    - op==3 and alu_b==0: resp_data={WIDTH{1'b1}}, resp_err=1 (alu_result ignored).
    - otherwise: resp_data=alu_result, resp_err=0.
  - resp_id is set to the latched id.
- RESP:
  - resp_valid=1; resp_data/resp_id/resp_err are held stable until the handshake.
  - On resp_ready=1: go to IDLE. No new grant happens in that same cycle.
  - On resp_ready=0: stay in RESP indefinitely (backpressure).
- Latency:
  - Handshake at edge T gives resp_valid high in cycle T+L+1.
  - Minimum issue interval is L+2 cycles when resp_ready is held high.
- No requester is accepted outside IDLE. Requesters must hold valid/a/b/op stable until ready.
- alu_a/alu_b/alu_op keep their last values after an op completes, until the next grant. There are no spurious toggles.
- busy = (state != IDLE).
- Simultaneous events:
  - rst has priority over everything.
  - A request that appears in the same cycle as the RESP handshake is granted in the following IDLE cycle.
- Unknown ops never stall the FSM. They take 1 cycle and return err.

Test Plan:
- Reset release, req0 valid with a=5, b=7, op=0 -> req0_ready=1 in first IDLE cycle; resp_valid 2 cycles after grant; resp_data=12, resp_id=0, resp_err=0; busy high during EXEC/RESP.
- Both requesters valid continuously with ops 1 (10-3) and 4 (0xF0F0&0xFF00), resp_ready=1 -> grants alternate 0,1,0,1; responses 7 (id0) and 0xF000 (id1) alternate; no requester starves.
- req0 op=3, a=100, b=7, DIV_CYCLES=4 -> alu_a/alu_b/alu_op stable for 4 EXEC cycles; resp_data=14 at grant+5.
- req1 op=3, b=0 -> resp_data=0xFFFFFFFF, resp_err=1. req0 op=7'h7F -> resp_data=0, resp_err=1, latency 2 cycles.
- resp_ready held low 10 cycles with req1 pending -> resp_valid and resp_data stable; req1_ready stays 0; req1 granted in the cycle after the handshake.
- rst asserted during EXEC of a MUL -> next cycle state IDLE, no resp_valid, all outputs 0; next request is served normally with req0 having tie priority.

Source files
------------

// File: rtl/alu_scheduler.sv
// Round-robin scheduler that shares one combinational ALU between two requesters.
// Operands are held on the ALU inputs for an op-dependent number of cycles before the result is returned.
module alu_scheduler #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned MUL_CYCLES = 2,
   parameter int unsigned DIV_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [6:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [6:0]       req1_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [6:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_id,
   output logic             resp_err,
   output logic             busy
);

   localparam int unsigned OPW  = 7;
   localparam int unsigned MAXL = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int unsigned CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

   localparam logic [OPW-1:0] OP_MUL = OPW'(2);
   localparam logic [OPW-1:0] OP_DIV = OPW'(3);
   localparam logic [OPW-1:0] OP_MAX = OPW'(10);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state;
   logic [CW-1:0]   counter;
   logic            last_grant;
   logic            id;

   logic            grant0_c;
   logic            grant1_c;
   logic [WIDTH-1:0] sel_a_c;
   logic [WIDTH-1:0] sel_b_c;
   logic [OPW-1:0]  sel_op_c;
   logic            op_err_c;
   logic            div_zero_c;

   // Extra hold cycles (L-1) for the op being granted.
   function automatic logic [CW-1:0] lat_m1(input logic [OPW-1:0] op);
      if (op == OP_MUL)      return CW'(MUL_CYCLES - 1);
      else if (op == OP_DIV) return CW'(DIV_CYCLES - 1);
      else                   return '0;
   endfunction

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      grant0_c = req0_valid && (!req1_valid || last_grant);
      grant1_c = req1_valid && (!req0_valid || !last_grant);
      sel_a_c  = grant1_c ? req1_a  : req0_a;
      sel_b_c  = grant1_c ? req1_b  : req0_b;
      sel_op_c = grant1_c ? req1_op : req0_op;
   end

   assign req0_ready = (state == IDLE) && grant0_c;
   assign req1_ready = (state == IDLE) && grant1_c;

   assign op_err_c   = alu_op > OP_MAX;
   assign div_zero_c = (alu_op == OP_DIV) && (alu_b == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         counter    <= '0;
         last_grant <= 1'b1;
         id         <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_id    <= 1'b0;
         resp_err   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0_c || grant1_c) begin
                  alu_a      <= sel_a_c;
                  alu_b      <= sel_b_c;
                  alu_op     <= sel_op_c;
                  id         <= grant1_c;
                  last_grant <= grant1_c;
                  counter    <= lat_m1(sel_op_c);
                  state      <= EXEC;
                  busy       <= 1'b1;
               end
            end
            EXEC: begin
               if (counter != '0) begin
                  counter <= counter - CW'(1);
               end else begin
                  resp_valid <= 1'b1;
                  resp_id    <= id;
                  state      <= RESP;
                  if (op_err_c) begin
                     resp_data <= '0;
                     resp_err  <= 1'b1;
                  end else if (div_zero_c) begin
                     resp_data <= '1;
                     resp_err  <= 1'b1;
                  end else begin
                     resp_data <= alu_result;
                     resp_err  <= 1'b0;
                  end
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a behavioural ALU attached to the scheduler outputs.
module tb_alu_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [6:0]  req0_op = '0, req1_op = '0;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [6:0]  alu_op;
   logic        resp_valid, resp_ready = 1'b1;
   logic [31:0] resp_data;
   logic        resp_id, resp_err, busy;

   int checks = 0;
   int errors = 0;

   alu_scheduler #(.WIDTH(32), .MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_id(resp_id), .resp_err(resp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural ALU; unknown ops return a marker value the scheduler must not forward.
   always_comb begin
      case (alu_op)
         7'd0:    alu_result = alu_a + alu_b;
         7'd1:    alu_result = alu_a - alu_b;
         7'd2:    alu_result = alu_a * alu_b;
         7'd3:    alu_result = (alu_b == 0) ? 32'd0 : alu_a / alu_b;
         7'd4:    alu_result = alu_a & alu_b;
         7'd5:    alu_result = alu_a | alu_b;
         7'd6:    alu_result = alu_a ^ alu_b;
         7'd10:   alu_result = alu_a << alu_b[4:0];
         default: alu_result = 32'hDEAD_BEEF;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits (bounded) for resp_valid at negedges; n = negedges waited.
   task automatic wait_resp(input string tag, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 40);
      if (!resp_valid) check({tag, "_timeout"}, {31'd0, resp_valid}, 32'd1);
   endtask

   // Issues one op from an idle scheduler and checks hold, latency and response.
   task automatic run_op(input string tag, input int rid, input logic [31:0] a, input logic [31:0] b,
                         input logic [6:0] op, input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
      int n;
      if (rid == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
      else          begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
      #1;
      check({tag, "_ready"}, {31'd0, (rid == 0) ? req0_ready : req1_ready}, 32'd1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!resp_valid) begin
            check({tag, "_hold_a"}, alu_a, a);
            check({tag, "_hold_b"}, alu_b, b);
            check({tag, "_hold_op"}, {25'd0, alu_op}, {25'd0, op});
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
         end
      end while (!resp_valid && n < 40);
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_data"}, resp_data, exp_d);
      check({tag, "_id"}, {31'd0, resp_id}, rid);
      check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_e});
      @(negedge clk);
      check({tag, "_done_valid"}, {31'd0, resp_valid}, 32'd0);
      check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      int t;
      int last_t;
      logic [31:0] exp_rr [2];

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_op", {25'd0, alu_op}, 32'd0);
      check("rst_data", resp_data, 32'd0);
      rst = 1'b0;

      // Basic add from req0, L=1
      run_op("add", 0, 32'd5, 32'd7, 7'd0, 32'd12, 1'b0, 2);

      // Round robin with both requesters always valid
      do_reset();
      exp_rr[0] = 32'd7;
      exp_rr[1] = 32'h0000_F000;
      req0_a = 32'd10;      req0_b = 32'd3;      req0_op = 7'd1;
      req1_a = 32'h0000_F0F0; req1_b = 32'h0000_FF00; req1_op = 7'd4;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      t = 0;
      last_t = 0;
      for (int k = 0; k < 4; k++) begin
         wait_resp("rr", n);
         t += n;
         check("rr_id", {31'd0, resp_id}, k % 2);
         check("rr_data", resp_data, exp_rr[k % 2]);
         if (k > 0) check("rr_gap", t - last_t, 32'd3);
         last_t = t;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      check("rr_idle", {31'd0, busy}, 32'd0);

      // Multicycle and error ops
      run_op("div", 0, 32'd100, 32'd7, 7'd3, 32'd14, 1'b0, 5);
      run_op("div0", 1, 32'd55, 32'd0, 7'd3, 32'hFFFF_FFFF, 1'b1, 5);
      run_op("bad7f", 0, 32'd9, 32'd9, 7'h7F, 32'd0, 1'b1, 2);
      run_op("mul", 1, 32'd6, 32'd7, 7'd2, 32'd42, 1'b0, 3);
      run_op("op10", 1, 32'd1, 32'd4, 7'd10, 32'd16, 1'b0, 2);
      run_op("op11", 0, 32'd1, 32'd4, 7'd11, 32'd0, 1'b1, 2);

      // Backpressure with req1 pending
      resp_ready = 1'b0;
      req0_a = 32'd1; req0_b = 32'd2; req0_op = 7'd0; req0_valid = 1'b1;
      #1;
      check("bp_ready0", {31'd0, req0_ready}, 32'd1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_a = 32'd20; req1_b = 32'd22; req1_op = 7'd0; req1_valid = 1'b1;
      wait_resp("bp", n);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_valid", {31'd0, resp_valid}, 32'd1);
         check("bp_data", resp_data, 32'd3);
         check("bp_ready1", {31'd0, req1_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      #1;
      check("bp_hs_ready1", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
      check("bp_after_ready1", {31'd0, req1_ready}, 32'd1);
      check("bp_after_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      wait_resp("bp2", n);
      check("bp2_data", resp_data, 32'd42);
      check("bp2_id", {31'd0, resp_id}, 32'd1);
      @(negedge clk);

      // Reset during a MUL in EXEC
      req0_a = 32'd6; req0_b = 32'd7; req0_op = 7'd2; req0_valid = 1'b1;
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      @(negedge clk);
      check("mrst_busy_exec", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mrst_busy", {31'd0, busy}, 32'd0);
      check("mrst_valid", {31'd0, resp_valid}, 32'd0);
      check("mrst_alu_a", alu_a, 32'd0);
      check("mrst_alu_b", alu_b, 32'd0);
      check("mrst_alu_op", {25'd0, alu_op}, 32'd0);
      check("mrst_data", resp_data, 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("mrst_no_resp", {31'd0, resp_valid}, 32'd0);
      end
      req0_a = 32'd1; req0_b = 32'd1; req0_op = 7'd0; req0_valid = 1'b1;
      req1_a = 32'd2; req1_b = 32'd2; req1_op = 7'd0; req1_valid = 1'b1;
      #1;
      check("mrst_tie_r0", {31'd0, req0_ready}, 32'd1);
      check("mrst_tie_r1", {31'd0, req1_ready}, 32'd0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_resp("mrst", n);
      check("mrst_lat", n, 32'd2);
      check("mrst_data2", resp_data, 32'd2);
      check("mrst_id", {31'd0, resp_id}, 32'd0);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
